// File: rtl/mvm_pkg.sv
// Shared types and requantisation helpers for the mvm datapath stages.
package mvm_pkg;

   typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} fsm_e;

   localparam int REQ_W = 32;

   function automatic int sat_hi(int out_w);
      return (1 << (out_w - 1)) - 1;
   endfunction

   function automatic int sat_lo(int out_w);
      return -(1 << (out_w - 1));
   endfunction

   // Round half up, arithmetic shift, optional ReLU, then clamp to out_w signed range.
   // REQ_W is wide enough that the rounding add never overflows for IN_W <= 31.
   function automatic logic signed [REQ_W-1:0] requant(logic signed [REQ_W-1:0] x,
                                                       int shift, int out_w, bit relu);
      logic signed [REQ_W-1:0] r, q;
      r = x + ((shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0);
      q = r >>> shift;
      if (relu && q < 0) q = 0;
      if (q > sat_hi(out_w))      q = sat_hi(out_w);
      else if (q < sat_lo(out_w)) q = sat_lo(out_w);
      return q;
   endfunction

endpackage

// File: rtl/mvm_requant_buffer_if.sv
// Burst-in / stream-out bundle of the requant buffer; slave is the buffer's view.
interface mvm_requant_buffer_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int LVL_W = 6
);
   logic                    done;
   logic signed [IN_W-1:0]  data_in;
   logic                    clr_ovf;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [LVL_W-1:0]        level;
   logic                    ovf_sticky;

   modport master (output done, data_in, clr_ovf, out_ready,
                   input  out_data, out_valid, level, ovf_sticky);
   modport slave  (input  done, data_in, clr_ovf, out_ready,
                   output out_data, out_valid, level, ovf_sticky);
endinterface

// File: rtl/mvm_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy output.
module mvm_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          valid,
   output logic [LW-1:0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wp, rp;
   logic [LW-1:0]           cnt;

   always_ff @(posedge clk)
      if (push) mem[wp] <= wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign valid = (cnt != '0);
   assign rdata = valid ? mem[rp] : '0;
   assign level = cnt;

endmodule

// File: rtl/mvm_requant_buffer.sv
// Captures the mvm result burst after done, requantises it and buffers it in a FWFT FIFO.
// Build option: define MVM_REQUANT_RELU_EN to clamp negative results to zero.
module mvm_requant_buffer
   import mvm_pkg::*;
#(
   parameter int M     = 12,
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int SHIFT = 4,
   parameter int DEPTH = 32
) (
   input logic                clk,
   input logic                reset,
   mvm_requant_buffer_if.slave bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(M + 1);
`ifdef MVM_REQUANT_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   fsm_e                    state, nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic                    push, pop, set_ovf, ovf, space_ok;
   logic [LW-1:0]           lvl;
   logic signed [REQ_W-1:0] din_ext;
   logic [OUT_W-1:0]        wr_data, rd_data;

   assign din_ext  = REQ_W'(bus.data_in);
   assign wr_data  = OUT_W'(requant(din_ext, SHIFT, OUT_W, RELU));
   // Room is judged once at the done edge; pops during the burst only add slack.
   assign space_ok = (DEPTH - int'(lvl)) >= M;
   assign pop      = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      push    = 1'b0;
      set_ovf = 1'b0;
      case (state)
         IDLE: begin
            if (bus.done) begin
               cnt_nxt = '0;
               if (space_ok) nxt = CAPTURE;
               else begin
                  nxt     = SKIP;
                  set_ovf = 1'b1;
               end
            end
         end
         CAPTURE, SKIP: begin
            push = (state == CAPTURE);
            if (cnt == CW'(M - 1)) begin
               nxt     = IDLE;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        ovf <= 1'b0;
      else if (set_ovf) ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
   end

   mvm_sync_fifo #(.W(OUT_W), .DEPTH(DEPTH), .LW(LW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wr_data),
      .pop   (pop),
      .rdata (rd_data),
      .valid (bus.out_valid),
      .level (lvl)
   );

   assign bus.out_data   = rd_data;
   assign bus.level      = lvl;
   assign bus.ovf_sticky = ovf;

endmodule

// File: tb/tb_mvm_requant_buffer.sv
// Self-checking bench for mvm_requant_buffer against a queue-based reference model.
module tb_mvm_requant_buffer;
   localparam int M     = 12;
   localparam int IN_W  = 16;
   localparam int OUT_W = 8;
   localparam int SHIFT = 4;
   localparam int DEPTH = 32;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mvm_requant_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LVL_W(LVL_W)) bus ();

   mvm_requant_buffer #(.M(M), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference requant from the arithmetic rules: floor((x + half) / 2^SHIFT), then clamp.
   function automatic int ref_requant(int x);
      int d, r, q;
      d = 1 << SHIFT;
      r = x + d / 2;
      if (r >= 0) q = r / d;
      else        q = -((-r + d - 1) / d);
`ifdef MVM_REQUANT_RELU_EN
      if (q < 0) q = 0;
`endif
      if (q > (1 << (OUT_W - 1)) - 1) q = (1 << (OUT_W - 1)) - 1;
      if (q < -(1 << (OUT_W - 1)))    q = -(1 << (OUT_W - 1));
      return q;
   endfunction

   // Behavioural model: expected FIFO contents, words left in the current burst, overflow flag.
   int mq[$];
   int m_rem, room;
   bit m_cap, m_ovf, m_pop, m_set;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_rem = 0;
         m_cap = 0;
         m_ovf = 0;
      end else begin
         m_pop = (mq.size() > 0) && (bus.out_ready === 1'b1);
         room  = DEPTH - mq.size();
         m_set = 0;
         if (m_pop) void'(mq.pop_front());
         if (m_rem > 0) begin
            if (m_cap) mq.push_back(ref_requant(int'(bus.data_in)));
            m_rem--;
         end else if (bus.done === 1'b1) begin
            m_rem = M;
            m_cap = (room >= M);
            m_set = !m_cap;
         end
         if (m_set) m_ovf = 1;
         else if (bus.clr_ovf === 1'b1) m_ovf = 0;
      end
   end

   task automatic send_burst(input int redone_at);
      @(negedge clk);
      bus.done    = 1'b1;
      bus.data_in = '0;
      for (int j = 0; j < M; j++) begin
         @(negedge clk);
         bus.done    = (j == redone_at);
         bus.data_in = IN_W'($urandom);
      end
      @(negedge clk);
      bus.done    = 1'b0;
      bus.data_in = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.done = 1'b0; bus.data_in = '0; bus.clr_ovf = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got=%0d want=0", bus.out_data); end
      checks++; if (bus.level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.level); end
      checks++; if (bus.ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.ovf_sticky); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_requant;
      int vals [M] = '{100, -8, -24, 30000, -30000, 0, 16, 16, 16, 16, 16, 16};
`ifdef MVM_REQUANT_RELU_EN
      int expv [M] = '{6, 0, 0, 127, 0, 0, 1, 1, 1, 1, 1, 1};
`else
      int expv [M] = '{6, 0, -1, 127, -128, 0, 1, 1, 1, 1, 1, 1};
`endif
      int got = 0;
      bus.out_ready = 1'b0;
      bus.done = 1'b1;
      for (int j = 0; j < M; j++) begin
         @(negedge clk);
         bus.done    = 1'b0;
         bus.data_in = IN_W'(vals[j]);
         checks++; if (bus.level !== LVL_W'(j)) begin errors++; $display("FAIL rq_fill_level j=%0d got=%0d want=%0d", j, bus.level, j); end
         if (j == 0) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rq_valid_early got=%b want=0", bus.out_valid); end
         end
         if (j == 1) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rq_valid_t2 got=%b want=1", bus.out_valid); end
         end
      end
      @(negedge clk);
      bus.data_in = '0;
      checks++; if (bus.level !== LVL_W'(M)) begin errors++; $display("FAIL rq_full_level got=%0d want=%0d", bus.level, M); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 40 && got < M; c++) begin
         if (bus.out_valid === 1'b1) begin
            checks++;
            if ($signed(bus.out_data) !== OUT_W'(expv[got])) begin
               errors++; $display("FAIL rq_word%0d got=%0d want=%0d", got, $signed(bus.out_data), expv[got]);
            end
            got++;
         end
         @(negedge clk);
      end
      checks++; if (got != M) begin errors++; $display("FAIL rq_count got=%0d want=%0d", got, M); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rq_drained got=%b want=0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic drain_check(input string name, input int n);
      int got = 0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4 * n + 10 && got < n; c++) begin
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (bus.out_data !== OUT_W'(mq[0])) begin
               errors++; $display("FAIL %s_word%0d got=%0d want=%0d", name, got, $signed(bus.out_data), mq[0]);
            end
            got++;
         end
         @(negedge clk);
      end
      checks++; if (got != n || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL %s_count got=%0d want=%0d valid=%b", name, got, n, bus.out_valid);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      bus.out_ready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         send_burst(-1);
         if (b == 1) begin
            checks++; if (bus.level !== LVL_W'(24) || bus.ovf_sticky !== 1'b0) begin
               errors++; $display("FAIL bp_two_bursts level=%0d ovf=%b want 24/0", bus.level, bus.ovf_sticky);
            end
         end
      end
      checks++; if (bus.level !== LVL_W'(24)) begin errors++; $display("FAIL bp_drop_level got=%0d want=24", bus.level); end
      checks++; if (bus.ovf_sticky !== 1'b1) begin errors++; $display("FAIL bp_ovf got=%b want=1", bus.ovf_sticky); end
      drain_check("bp", 24);
      checks++; if (bus.ovf_sticky !== 1'b1) begin errors++; $display("FAIL bp_ovf_hold got=%b want=1", bus.ovf_sticky); end
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      checks++; if (bus.ovf_sticky !== 1'b0) begin errors++; $display("FAIL bp_clr got=%b want=0", bus.ovf_sticky); end
   endtask

   task automatic test_concurrent;
      int seen = 0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.done = 1'b1;
      for (int j = 0; j <= M; j++) begin
         @(negedge clk);
         bus.done    = 1'b0;
         bus.data_in = (j < M) ? IN_W'($urandom) : '0;
         checks++; if (bus.level > LVL_W'(1) || bus.level !== LVL_W'(mq.size())) begin
            errors++; $display("FAIL cc_level j=%0d got=%0d want=%0d", j, bus.level, mq.size());
         end
         if (j >= 1) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== OUT_W'(mq[0])) begin
               errors++; $display("FAIL cc_word j=%0d valid=%b got=%0d want=%0d", j, bus.out_valid, $signed(bus.out_data), mq[0]);
            end
            seen++;
         end
      end
      @(negedge clk);
      checks++; if (seen != M || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL cc_count got=%0d want=%0d valid=%b", seen, M, bus.out_valid);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.done = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         bus.done    = 1'b0;
         bus.data_in = IN_W'($urandom);
      end
      @(negedge clk);
      checks++; if (bus.level !== LVL_W'(5)) begin errors++; $display("FAIL rm_pre_level got=%0d want=5", bus.level); end
      bus.data_in = IN_W'($urandom);
      reset = 1'b1;
      #1;
      checks++; if (bus.level !== '0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rm_async level=%0d valid=%b want 0/0", bus.level, bus.out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int j = 6; j < M; j++) begin
         bus.data_in = IN_W'($urandom);
         @(negedge clk);
      end
      bus.data_in = '0;
      checks++; if (bus.level !== '0) begin errors++; $display("FAIL rm_tail_ignored got=%0d want=0", bus.level); end
      send_burst(-1);
      checks++; if (bus.level !== LVL_W'(M)) begin errors++; $display("FAIL rm_new_level got=%0d want=%0d", bus.level, M); end
      drain_check("rm", M);
   endtask

   task automatic test_done_during_capture;
      bus.out_ready = 1'b0;
      send_burst(3);
      checks++; if (bus.level !== LVL_W'(M)) begin errors++; $display("FAIL dd_mid got=%0d want=%0d", bus.level, M); end
      send_burst(M - 1);
      repeat (2) @(negedge clk);
      checks++; if (bus.level !== LVL_W'(2 * M)) begin errors++; $display("FAIL dd_last got=%0d want=%0d", bus.level, 2 * M); end
      drain_check("dd", 2 * M);
   endtask

   initial begin
      test_reset;
      test_requant;
      test_backpressure;
      test_concurrent;
      test_reset_mid;
      test_done_during_capture;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mvm_requant_buffer.md
Name: mvm_requant_buffer

Overview:
- Downstream stage of the matrix-vector multiplier (mvm). Captures the M-word result burst that follows the mvm `done` pulse.
- Requantises each OUTPUT_WIDTH product-sum back to INPUT_WIDTH: rounded arithmetic shift, then saturation.
- Buffers results in a FIFO and presents them on a valid/ready stream. The next layer's vector load can consume them at its own pace.

Parameters:
- M, 12, number of result words per burst (matrix rows)
- IN_W, 16, width of the mvm result word (mvm OUTPUT_WIDTH)
- OUT_W, 8, width of the requantised word (mvm INPUT_WIDTH)
- SHIFT, 4, right-shift amount; range 0..IN_W-1
- DEPTH, 32, FIFO depth in words; power of two; must be >= M

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- done  in  1  mvm done; result words follow on the next M cycles
- data_in  in  IN_W  signed mvm data_out
- clr_ovf  in  1  synchronous clear of ovf_sticky
- out_data  out  OUT_W  signed requantised word, valid when out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both 1 at a rising edge
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- ovf_sticky  out  1  a burst was dropped because the FIFO lacked space

Behaviour:
- Reset values: out_valid=0, out_data=0, level=0, ovf_sticky=0. FSM resets to IDLE, burst counter 0, FIFO read/write pointers 0.
- Burst timing: done is sampled 1 at edge t. Result word j (j=0..M-1) is sampled from data_in at edge t+1+j.
- FSM states:
  - IDLE: on done=1, if (DEPTH-level) >= M go to CAPTURE; otherwise set ovf_sticky and go to SKIP. Counter=0 in both cases.
  - CAPTURE: each edge, write requant(data_in) to FIFO and increment counter. After the M-th write, return to IDLE.
  - SKIP: each edge, increment counter, discard data_in. After M cycles, return to IDLE.
  - done=1 while in CAPTURE or SKIP is ignored; it is not queued.
- Space check is made once, at the done edge, using the level at that edge. Pops during the burst only add slack, so a write into a full FIFO cannot occur.
- Requant, with signed arithmetic throughout:
  - Step 1: r = data_in + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed at IN_W+1 bits.
  - Step 2: q = r >>> SHIFT (rounds half up).
  - Step 3: saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Purely combinational between data_in and the FIFO write port; no extra latency.
- FIFO:
  - First-word fall-through: out_data shows the head word whenever out_valid=1.
  - A written word is visible on out_data on the edge following its write (registered write).
  - A simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - Popping when empty is impossible, since a pop requires out_valid.
- ovf_sticky: set by a dropped burst; cleared only by clr_ovf=1 or reset. If set and clear occur on the same edge, set wins.
- Reset asserted mid-burst: all state clears immediately, including a partial burst and FIFO contents. Remaining words of that burst are ignored; the block waits for a fresh done.

Optional Feature:
- Macro MVM_REQUANT_RELU_EN.
- Defined: q is clamped to 0 when negative, before saturation. Output range becomes [0, 2^(OUT_W-1)-1].
- Undefined: signed saturation only, as above.

Decomposition:
- Package mvm_pkg holds:
  - fsm enum typedef {IDLE, CAPTURE, SKIP}
  - localparam helpers for the saturation bounds
  - the requant function, shared with any future requantising stage
- One natural sub-module: mvm_sync_fifo (parameterised width/depth, FWFT, level output), instantiated once.

Test Plan:
- Requant values, SHIFT=4, no ReLU. Burst data_in 100, -8, -24, 30000, -30000, 0, then 6 copies of 16 → out_data 6, 0, -1, 127, -128, 0, then 1 ×6. out_valid high from edge t+2 until drained.
- ReLU build, same burst → 6, 0, 0, 127, 0, 0, then 1 ×6.
- Backpressure: out_ready=0 through three bursts (36 > DEPTH=32). Bursts 1–2 captured, level=24. Burst 3 dropped, ovf_sticky=1, level stays 24. Then out_ready=1 → 24 words drained in order. clr_ovf pulse → ovf_sticky=0.
- Concurrent push/pop: out_ready=1 throughout a burst → level never exceeds 1, and all M words emerge in order on consecutive cycles.
- Reset mid-burst: reset asserted after the 5th captured word → level=0 and out_valid=0 immediately. The following done+burst of 12 words → exactly 12 words output, matching the new burst.
- done re-asserted during CAPTURE → ignored; exactly M words captured for that burst.
